// File: rtl/ifetch_stage.sv
// ---------------------------------------------------------------------------
// ifetch_stage
//
// Instruction-fetch stage feeding decode. Holds the PC and the instruction
// register (IR), fetches from a variable-latency instruction memory with a
// req/ack handshake, and offers one instruction at a time to decode with a
// valid/ready handshake. The next PC is either PC+4 or PC+4+PC_Immed, where
// PC_Immed arrives from decode already sign-extended and shifted left by 2.
//
// Ports:
//   Clk          clock, all registers on the rising edge
//   Reset        asynchronous, active-high reset
//   PC_sel       0: next PC = PC+4, 1: next PC = PC+4+PC_Immed
//   PC_Immed     branch offset (two's complement, already word-scaled)
//   PC_LdEn      controller permission to advance the PC
//   Instr_ready  decode accepts the current instruction
//   Imem_rdata   instruction word from memory
//   Imem_ack     memory has valid Imem_rdata this cycle
//   Imem_req     fetch request, high for the whole FETCH state
//   Imem_addr    fetch address, always equal to PC
//   Instr        IR contents
//   PC           address of the instruction in IR or being fetched
//   Instr_valid  IR holds an instruction not yet consumed
//   Fetch_fault  sticky fault flag, cleared only by Reset
//   Fault_cause  0: memory timeout, 1: misaligned branch target
//
// Parameters:
//   RESET_PC     PC value loaded on reset
//   TIMEOUT_CYC  FETCH cycles without ack before faulting (2..255)
// ---------------------------------------------------------------------------
module ifetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PC_sel,
  input  logic [31:0] PC_Immed,
  input  logic        PC_LdEn,
  input  logic        Instr_ready,
  input  logic [31:0] Imem_rdata,
  input  logic        Imem_ack,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic        Instr_valid,
  output logic        Fetch_fault,
  output logic        Fault_cause
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Last counter value that is still allowed to wait for an ack; the
  // counter starts at 0 in the first FETCH cycle, so reaching this value
  // without an ack means TIMEOUT_CYC FETCH cycles have elapsed.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cause_q, cause_d;
  logic [31:0] target;

  // Next-PC arithmetic, modulo 2^32 (PC 32'hFFFF_FFFC + 4 wraps to 0).
  function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                          input logic        sel,
                                          input logic [31:0] immed);
    logic [31:0] offset;
    offset  = sel ? immed : 32'd0;
    next_pc = pc + 32'd4 + offset;
  endfunction

  // A target is only usable when it is word aligned.
  function automatic logic is_aligned(input logic [31:0] addr);
    is_aligned = (addr[1:0] == 2'b00);
  endfunction

  assign target = next_pc(pc_q, PC_sel, PC_Immed);

  // ---- state and datapath registers ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      cnt_q   <= 8'd0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // ---- next-state and datapath update ----
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        cnt_d   = 8'd0;
      end

      FETCH: begin
        if (Imem_ack) begin
          ir_d    = Imem_rdata;
          cnt_d   = 8'd0;
          state_d = HOLD;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cause_d = 1'b0;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        // Imem_ack is ignored here so a stray ack cannot corrupt IR.
        if (Instr_ready && PC_LdEn) begin
          if (is_aligned(target)) begin
            pc_d    = target;
            cnt_d   = 8'd0;
            state_d = FETCH;
          end else begin
            // PC is deliberately left pointing at the offending branch.
            cause_d = 1'b1;
            state_d = FAULT;
          end
        end
      end

      FAULT: begin
        // Terminal: everything frozen until Reset.
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- outputs, decoded directly from state ----
  assign Imem_req    = (state_q == FETCH);
  assign Instr_valid = (state_q == HOLD);
  assign Fetch_fault = (state_q == FAULT);
  assign Fault_cause = cause_q;
  assign Imem_addr   = pc_q;
  assign PC          = pc_q;
  assign Instr       = ir_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// ---------------------------------------------------------------------------
// tb_ifetch_stage
//
// Directed bench for ifetch_stage. A small memory model answers requests
// after a programmable number of wait cycles with data 32'h1111_0000+addr.
// A per-cycle vector table covers sequential fetch, forward/backward
// branches, PC wrap-around and the misaligned-target fault; hand-written
// sequences cover wait states, stray acks in HOLD, stalls, timeout and
// asynchronous reset in the middle of a fetch.
// ---------------------------------------------------------------------------
module tb_ifetch_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PC_sel = 1'b0;
  logic [31:0] PC_Immed = 32'd0;
  logic        PC_LdEn = 1'b0;
  logic        Instr_ready = 1'b0;
  logic [31:0] Imem_rdata;
  logic        Imem_ack;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic        Instr_valid;
  logic        Fetch_fault;
  logic        Fault_cause;

  // memory model controls
  logic [7:0]  mem_lat = 8'd0;
  logic        ack_en = 1'b1;
  logic        ack_force = 1'b0;
  logic [7:0]  lat_cnt;

  int total = 0;
  int bad   = 0;

  ifetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .TIMEOUT_CYC(16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PC_sel     (PC_sel),
    .PC_Immed   (PC_Immed),
    .PC_LdEn    (PC_LdEn),
    .Instr_ready(Instr_ready),
    .Imem_rdata (Imem_rdata),
    .Imem_ack   (Imem_ack),
    .Imem_req   (Imem_req),
    .Imem_addr  (Imem_addr),
    .Instr      (Instr),
    .PC         (PC),
    .Instr_valid(Instr_valid),
    .Fetch_fault(Fetch_fault),
    .Fault_cause(Fault_cause)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Reset || !Imem_req || Imem_ack) lat_cnt <= 8'd0;
    else                                lat_cnt <= lat_cnt + 8'd1;
  end

  assign Imem_ack   = ack_force | (ack_en & Imem_req & (lat_cnt == mem_lat));
  assign Imem_rdata = ack_force ? 32'hDEAD_BEEF : (32'h1111_0000 + Imem_addr);

  typedef struct {
    logic        exp_req;
    logic        exp_vld;
    logic        exp_flt;
    logic        exp_cause;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic        rdy;
    logic        ld;
    logic        sel;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic req, input logic vld, input logic flt,
                         input logic cause, input logic [31:0] addr,
                         input logic [31:0] instr, input logic rdy,
                         input logic ld, input logic sel,
                         input logic [31:0] imm);
    vec_t v;
    v.exp_req = req;   v.exp_vld = vld;   v.exp_flt = flt;
    v.exp_cause = cause; v.exp_addr = addr; v.exp_instr = instr;
    v.rdy = rdy; v.ld = ld; v.sel = sel; v.imm = imm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with Reset low, DUT in IDLE.
  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    // ---- reset state ----
    mem_lat = 8'd0; ack_en = 1'b1;
    Reset = 1'b1;
    step();
    step();
    chk("rst_req",   Imem_req,    1'b0);
    chk("rst_vld",   Instr_valid, 1'b0);
    chk("rst_flt",   Fetch_fault, 1'b0);
    chk("rst_cause", Fault_cause, 1'b0);
    chk("rst_pc",    PC,          32'h0);
    chk("rst_ir",    Instr,       32'h0);

    // ---- table: zero-wait memory, sequential fetch, branches, wrap, fault ----
    //        req vld flt cs  addr           instr          rdy ld sel imm
    add_vec(0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 1, 1, 0, 32'h0);
    add_vec(1, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 1, 1, 0, 32'h0);
    add_vec(0, 1, 0, 0, 32'h0000_0000, 32'h1111_0000, 1, 1, 0, 32'h0);
    add_vec(1, 0, 0, 0, 32'h0000_0004, 32'h1111_0000, 1, 1, 0, 32'h0);
    add_vec(0, 1, 0, 0, 32'h0000_0004, 32'h1111_0004, 1, 1, 0, 32'h0);
    add_vec(1, 0, 0, 0, 32'h0000_0008, 32'h1111_0004, 1, 1, 0, 32'h0);
    add_vec(0, 1, 0, 0, 32'h0000_0008, 32'h1111_0008, 1, 1, 0, 32'h0);
    add_vec(1, 0, 0, 0, 32'h0000_000C, 32'h1111_0008, 1, 1, 0, 32'h0);
    add_vec(0, 1, 0, 0, 32'h0000_000C, 32'h1111_000C, 1, 1, 0, 32'h0);
    add_vec(1, 0, 0, 0, 32'h0000_0010, 32'h1111_000C, 1, 1, 0, 32'h0);
    add_vec(0, 1, 0, 0, 32'h0000_0010, 32'h1111_0010, 1, 1, 1, 32'hFFFF_FFF0);
    add_vec(1, 0, 0, 0, 32'h0000_0004, 32'h1111_0010, 1, 1, 1, 32'h0000_0008);
    add_vec(0, 1, 0, 0, 32'h0000_0004, 32'h1111_0004, 1, 1, 1, 32'h0000_0008);
    add_vec(1, 0, 0, 0, 32'h0000_0010, 32'h1111_0004, 1, 1, 1, 32'h0000_0100);
    add_vec(0, 1, 0, 0, 32'h0000_0010, 32'h1111_0010, 1, 1, 1, 32'h0000_0100);
    add_vec(1, 0, 0, 0, 32'h0000_0114, 32'h1111_0010, 1, 1, 1, 32'hFFFF_FEE4);
    add_vec(0, 1, 0, 0, 32'h0000_0114, 32'h1111_0114, 1, 1, 1, 32'hFFFF_FEE4);
    add_vec(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h1111_0114, 1, 1, 0, 32'h0);
    add_vec(0, 1, 0, 0, 32'hFFFF_FFFC, 32'h1110_FFFC, 1, 1, 0, 32'h0);
    add_vec(1, 0, 0, 0, 32'h0000_0000, 32'h1110_FFFC, 1, 1, 1, 32'h0000_0002);
    add_vec(0, 1, 0, 0, 32'h0000_0000, 32'h1111_0000, 1, 1, 1, 32'h0000_0002);
    add_vec(0, 0, 1, 1, 32'h0000_0000, 32'h1111_0000, 1, 1, 1, 32'h0000_0002);
    add_vec(0, 0, 1, 1, 32'h0000_0000, 32'h1111_0000, 1, 1, 0, 32'h0);

    Instr_ready = 1'b1; PC_LdEn = 1'b1; PC_sel = 1'b0; PC_Immed = 32'h0;
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("v%0d_req", i),   Imem_req,    vecs[i].exp_req);
      chk($sformatf("v%0d_vld", i),   Instr_valid, vecs[i].exp_vld);
      chk($sformatf("v%0d_flt", i),   Fetch_fault, vecs[i].exp_flt);
      chk($sformatf("v%0d_cause", i), Fault_cause, vecs[i].exp_cause);
      chk($sformatf("v%0d_addr", i),  Imem_addr,   vecs[i].exp_addr);
      chk($sformatf("v%0d_pc", i),    PC,          vecs[i].exp_addr);
      chk($sformatf("v%0d_instr", i), Instr,       vecs[i].exp_instr);
      Instr_ready = vecs[i].rdy;
      PC_LdEn     = vecs[i].ld;
      PC_sel      = vecs[i].sel;
      PC_Immed    = vecs[i].imm;
      step();
    end

    // ---- 3 wait states: req held 4 cycles with stable address ----
    mem_lat = 8'd3; ack_en = 1'b1;
    Instr_ready = 1'b0; PC_LdEn = 1'b0; PC_sel = 1'b0; PC_Immed = 32'h0;
    do_reset();
    step();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (!Imem_req) break;
      n++;
      chk("wait_addr", Imem_addr, 32'h0);
      step();
    end
    chk("wait_req_cycles", n, 4);
    chk("wait_vld",   Instr_valid, 1'b1);
    chk("wait_instr", Instr,       32'h1111_0000);

    // stray ack while holding must not touch IR
    ack_force = 1'b1;
    step();
    step();
    ack_force = 1'b0;
    chk("hold_ack_instr", Instr,       32'h1111_0000);
    chk("hold_ack_vld",   Instr_valid, 1'b1);
    chk("hold_ack_req",   Imem_req,    1'b0);

    // ---- stall: ready without load enable ----
    Instr_ready = 1'b1; PC_LdEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall%0d_pc", i),    PC,          32'h0);
      chk($sformatf("stall%0d_instr", i), Instr,       32'h1111_0000);
      chk($sformatf("stall%0d_vld", i),   Instr_valid, 1'b1);
    end
    PC_LdEn = 1'b1;
    step();
    chk("unstall_req",  Imem_req,  1'b1);
    chk("unstall_addr", Imem_addr, 32'h0000_0004);

    // ---- memory timeout ----
    ack_en = 1'b0;
    Instr_ready = 1'b1; PC_LdEn = 1'b1; PC_sel = 1'b0;
    do_reset();
    step();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!Imem_req) break;
      n++;
      step();
    end
    chk("tmo_fetch_cycles", n, 16);
    chk("tmo_flt",   Fetch_fault, 1'b1);
    chk("tmo_cause", Fault_cause, 1'b0);
    chk("tmo_req",   Imem_req,    1'b0);
    chk("tmo_vld",   Instr_valid, 1'b0);
    chk("tmo_pc",    PC,          32'h0);
    ack_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("tmo_sticky_flt", Fetch_fault, 1'b1);
    chk("tmo_sticky_req", Imem_req,    1'b0);
    Reset = 1'b1;
    #1;
    chk("tmo_rst_flt",   Fetch_fault, 1'b0);
    chk("tmo_rst_cause", Fault_cause, 1'b0);

    // ---- asynchronous reset in the middle of a fetch at PC=0x20 ----
    mem_lat = 8'd5; ack_en = 1'b1;
    Instr_ready = 1'b1; PC_LdEn = 1'b1; PC_sel = 1'b0; PC_Immed = 32'h0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if (Imem_req && Imem_addr == 32'h0000_0020) break;
      step();
    end
    chk("arst_reach_req",  Imem_req,  1'b1);
    chk("arst_reach_addr", Imem_addr, 32'h0000_0020);
    #3;
    Reset = 1'b1;
    #1;
    chk("arst_pc",    PC,          32'h0);
    chk("arst_req",   Imem_req,    1'b0);
    chk("arst_instr", Instr,       32'h0);
    chk("arst_vld",   Instr_valid, 1'b0);
    step();
    Reset = 1'b0;
    chk("arst_idle_req", Imem_req, 1'b0);
    step();
    chk("arst_refetch_req",  Imem_req,  1'b1);
    chk("arst_refetch_addr", Imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
